// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader: receiver state encoding and UART framing constants.
package uart_boot_loader_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_boot_loader_rx.sv
// 8N1 UART receiver: input synchroniser, framing FSM and LSB-first shift register.
module uart_rx
  import uart_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_pulse_o,
  output logic       busy_o
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             rx_meta_q, rx_sync_q;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start bit.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    bit_d             = bit_q;
    shift_d           = shift_q;
    byte_valid_o      = 1'b0;
    frame_err_pulse_o = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          if (rx_sync_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = '0;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_q == LAST_BIT) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            state_d      = RX_IDLE;
            byte_valid_o = 1'b1;
          end else begin
            state_d           = RX_WAIT_HIGH;
            frame_err_pulse_o = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // A held-low line (break) must return high before a new start bit is accepted.
      RX_WAIT_HIGH: begin
        if (rx_sync_q) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o = shift_q;
  assign busy_o = (state_q != RX_IDLE);

endmodule

// File: rtl/uart_boot_loader.sv
// Feeds received UART bytes to the control unit's boot-loader port as {address, data} write strobes.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT         = DEFAULT_CLKS_PER_BIT,
  parameter int REGISTER_WIDTH       = 4,
  parameter int MEMORY_ADDRESS_WIDTH = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            prog_sw_i,
  input  logic                            rx_i,
  input  logic                            p_active_i,
  output logic                            p_programm_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] p_address_o,
  output logic [REGISTER_WIDTH-1:0]       p_data_o,
  output logic                            p_write_en_mem_o,
  output logic                            frame_err_o,
  output logic [MEMORY_ADDRESS_WIDTH:0]   words_written_o,
  output logic                            rx_busy_o
);

  localparam logic [MEMORY_ADDRESS_WIDTH:0] WORDS_MAX = '1;

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  logic                            prog_meta_q, prog_sync_q, prog_prev_q;
  logic [MEMORY_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [REGISTER_WIDTH-1:0]       data_q, data_d;
  logic                            we_q, we_d;
  logic                            ferr_q, ferr_d;
  logic [MEMORY_ADDRESS_WIDTH:0]   words_q, words_d;
  logic                            session_start, write_fire;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .rx_i             (rx_i),
    .byte_o           (rx_byte),
    .byte_valid_o     (rx_valid),
    .frame_err_pulse_o(rx_ferr),
    .busy_o           (rx_busy_o)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prog_meta_q <= 1'b0;
      prog_sync_q <= 1'b0;
      prog_prev_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      ferr_q      <= 1'b0;
      words_q     <= '0;
    end else begin
      prog_meta_q <= prog_sw_i;
      prog_sync_q <= prog_meta_q;
      prog_prev_q <= prog_sync_q;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      ferr_q      <= ferr_d;
      words_q     <= words_d;
    end
  end

  // p_active_i is checked at the stop-bit sample, so a switch released mid-byte drops the byte.
  assign session_start = prog_sync_q & ~prog_prev_q;
  assign write_fire    = rx_valid & p_active_i;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = write_fire;
    ferr_d  = ferr_q;
    words_d = words_q;
    if (write_fire) begin
      addr_d = rx_byte[7:4];
      data_d = rx_byte[3:0];
    end
    if (rx_ferr) begin
      ferr_d = 1'b1;
    end else if (session_start) begin
      ferr_d = 1'b0;
    end
    if (session_start) begin
      words_d = '0;
    end else if (write_fire && (words_q != WORDS_MAX)) begin
      words_d = words_q + 1'b1;
    end
  end

  assign p_programm_o     = prog_sync_q;
  assign p_address_o      = addr_q;
  assign p_data_o         = data_q;
  assign p_write_en_mem_o = we_q;
  assign frame_err_o      = ferr_q;
  assign words_written_o  = words_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader with a 4-clock UART bit period.
module tb_uart_boot_loader;

  localparam int CPB = 4;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       prog_sw_i;
  logic       rx_i;
  logic       p_active_i;
  logic       p_programm_o;
  logic [3:0] p_address_o;
  logic [3:0] p_data_o;
  logic       p_write_en_mem_o;
  logic       frame_err_o;
  logic [4:0] words_written_o;
  logic       rx_busy_o;

  int errors = 0;
  int checks = 0;
  logic [7:0] wq[$];

  uart_boot_loader #(
    .CLKS_PER_BIT        (CPB),
    .REGISTER_WIDTH      (4),
    .MEMORY_ADDRESS_WIDTH(4)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .prog_sw_i       (prog_sw_i),
    .rx_i            (rx_i),
    .p_active_i      (p_active_i),
    .p_programm_o    (p_programm_o),
    .p_address_o     (p_address_o),
    .p_data_o        (p_data_o),
    .p_write_en_mem_o(p_write_en_mem_o),
    .frame_err_o     (frame_err_o),
    .words_written_o (words_written_o),
    .rx_busy_o       (rx_busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (p_write_en_mem_o === 1'b1) wq.push_back({p_address_o, p_data_o});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_bit(input logic v);
    rx_i = v;
    repeat (CPB) @(negedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  initial begin
    reset_i    = 1'b1;
    prog_sw_i  = 1'b0;
    rx_i       = 1'b1;
    p_active_i = 1'b0;
    idle(4);
    reset_i = 1'b0;
    idle(2);

    // Reset asserted part-way through a byte
    send_bit(1'b0);
    send_bit(1'b1);
    chk("busy_mid_byte", 32'(rx_busy_o), 32'd1);
    reset_i = 1'b1;
    #1;
    chk("busy_in_reset", 32'(rx_busy_o), 32'd0);
    rx_i = 1'b1;
    idle(3);
    reset_i = 1'b0;
    idle(60);
    chk("rst_prog", 32'(p_programm_o), 32'd0);
    chk("rst_addr", 32'(p_address_o), 32'd0);
    chk("rst_data", 32'(p_data_o), 32'd0);
    chk("rst_we", 32'(p_write_en_mem_o), 32'd0);
    chk("rst_ferr", 32'(frame_err_o), 32'd0);
    chk("rst_words", 32'(words_written_o), 32'd0);
    chk("rst_busy", 32'(rx_busy_o), 32'd0);
    chk("rst_no_strobe", 32'(wq.size()), 32'd0);

    // Normal load: strobe exactly one cycle after the stop-bit sample
    prog_sw_i  = 1'b1;
    p_active_i = 1'b1;
    @(negedge clk_i);
    chk("prog_lag1", 32'(p_programm_o), 32'd0);
    idle(2);
    chk("prog_lag3", 32'(p_programm_o), 32'd1);
    send_byte(8'h5A, 1'b1);
    chk("load_we_early", 32'(p_write_en_mem_o), 32'd0);
    @(negedge clk_i);
    chk("load_we", 32'(p_write_en_mem_o), 32'd1);
    chk("load_addr", 32'(p_address_o), 32'h5);
    chk("load_data", 32'(p_data_o), 32'hA);
    chk("load_words", 32'(words_written_o), 32'd1);
    @(negedge clk_i);
    chk("load_we_one_cycle", 32'(p_write_en_mem_o), 32'd0);
    idle(4);
    chk("load_strobes", 32'(wq.size()), 32'd1);

    // Inactive: byte received then dropped
    p_active_i = 1'b0;
    send_byte(8'h37, 1'b1);
    idle(6);
    chk("drop_strobes", 32'(wq.size()), 32'd1);
    chk("drop_words", 32'(words_written_o), 32'd1);
    chk("drop_addr", 32'(p_address_o), 32'h5);
    chk("drop_data", 32'(p_data_o), 32'hA);
    chk("drop_ferr", 32'(frame_err_o), 32'd0);

    // Framing error followed by a held-low line
    p_active_i = 1'b1;
    send_byte(8'h12, 1'b0);
    rx_i = 1'b0;
    idle(20);
    chk("ferr_set", 32'(frame_err_o), 32'd1);
    chk("ferr_wait_high_busy", 32'(rx_busy_o), 32'd1);
    rx_i = 1'b1;
    idle(8);
    chk("ferr_idle", 32'(rx_busy_o), 32'd0);
    chk("ferr_no_strobe", 32'(wq.size()), 32'd1);
    chk("ferr_words", 32'(words_written_o), 32'd1);
    send_byte(8'h34, 1'b1);
    idle(4);
    chk("after_ferr_addr", 32'(p_address_o), 32'h3);
    chk("after_ferr_data", 32'(p_data_o), 32'h4);
    chk("after_ferr_words", 32'(words_written_o), 32'd2);
    chk("ferr_sticky", 32'(frame_err_o), 32'd1);
    chk("after_ferr_strobes", 32'(wq.size()), 32'd2);

    // New session clears the flag and counter
    prog_sw_i = 1'b0;
    idle(4);
    chk("sess_prog_low", 32'(p_programm_o), 32'd0);
    chk("sess_ferr_kept", 32'(frame_err_o), 32'd1);
    prog_sw_i = 1'b1;
    idle(4);
    chk("sess_prog_high", 32'(p_programm_o), 32'd1);
    chk("sess_ferr_clr", 32'(frame_err_o), 32'd0);
    chk("sess_words_clr", 32'(words_written_o), 32'd0);

    // One-cycle glitch enters START then returns to IDLE
    rx_i = 1'b0;
    @(negedge clk_i);
    rx_i = 1'b1;
    idle(2);
    chk("glitch_start_busy", 32'(rx_busy_o), 32'd1);
    idle(10);
    chk("glitch_idle", 32'(rx_busy_o), 32'd0);
    chk("glitch_ferr", 32'(frame_err_o), 32'd0);
    chk("glitch_strobes", 32'(wq.size()), 32'd2);
    chk("glitch_words", 32'(words_written_o), 32'd0);

    // Back-to-back bytes, 1 stop bit apart
    wq.delete();
    for (int i = 0; i < 16; i++) send_byte(8'(i << 4), 1'b1);
    send_byte(8'h01, 1'b1);
    idle(6);
    chk("b2b_count", 32'(wq.size()), 32'd17);
    for (int i = 0; i < 17; i++) begin
      if (i < wq.size()) chk($sformatf("b2b_byte%0d", i), 32'(wq[i]), (i < 16) ? 32'(i << 4) : 32'h01);
    end
    chk("b2b_words", 32'(words_written_o), 32'd17);

    // Counter saturation at 31
    for (int i = 0; i < 15; i++) send_byte(8'hC3, 1'b1);
    idle(4);
    chk("sat_words31", 32'(words_written_o), 32'd31);
    send_byte(8'h9E, 1'b1);
    idle(4);
    chk("sat_hold", 32'(words_written_o), 32'd31);
    chk("sat_addr", 32'(p_address_o), 32'h9);
    chk("sat_data", 32'(p_data_o), 32'hE);
    chk("sat_strobes", 32'(wq.size()), 32'd33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
